// File: rtl/data_mem_hs.sv
// Single-port data memory with req/ready/rvalid handshake, byte-enable writes,
// WAIT_STATES (0..15) extra cycles per access and out-of-range error reporting.
module data_mem_hs #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic                    ready,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  // One extra bit so DEPTH is representable even when it equals 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_we_q, hold_we_d;
  logic                  hold_err_q, hold_err_d;

  // Zero only at elaboration; reset deliberately leaves contents intact.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic                  accept;
  logic                  in_range;
  logic [IdxW-1:0]       idx;
  logic [DATA_WIDTH-1:0] rd_word;

  assign ready    = (state_q == StIdle);
  assign accept   = req && ready;
  assign in_range = ({1'b0, addr} < DepthExt);
  assign idx      = addr[IdxW-1:0];
  assign rd_word  = in_range ? mem[idx] : '0;

  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rdata  = rdata_q;

  always_ff @(posedge clock) begin
    if (accept && we && in_range) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    hold_d     = hold_q;
    hold_we_d  = hold_we_q;
    hold_err_d = hold_err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          hold_d     = rd_word;
          hold_we_d  = we;
          hold_err_d = !in_range;
          if (WAIT_STATES == 0) begin
            rvalid_d = 1'b1;
            err_d    = !in_range;
            if (!we) begin
              rdata_d = rd_word;
            end
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d  = StIdle;
          rvalid_d = 1'b1;
          err_d    = hold_err_q;
          if (!hold_we_q) begin
            rdata_d = hold_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      hold_q     <= '0;
      hold_we_q  <= 1'b0;
      hold_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      hold_q     <= hold_d;
      hold_we_q  <= hold_we_d;
      hold_err_q <= hold_err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: one instance with no wait states, one with three,
// checked against an array model of memory contents and handshake timing.
module tb_data_mem_hs;

  logic        clock = 1'b0;
  logic        rst;
  logic        req    [2];
  logic        we     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [3:0]  be     [2];
  logic        ready  [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];

  logic [31:0] model   [2][1024];
  logic [31:0] last_rd [2];
  int          acc_cnt [2];
  int          rv_cnt  [2];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clock = ~clock;

  data_mem_hs #(.WAIT_STATES(0)) u_w0 (
    .clock(clock), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .be(be[0]), .ready(ready[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .err(err[0])
  );

  data_mem_hs #(.WAIT_STATES(3)) u_w3 (
    .clock(clock), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .be(be[1]), .ready(ready[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .err(err[1])
  );

  always @(negedge clock) begin
    if (rvalid[0] === 1'b1) rv_cnt[0]++;
    if (rvalid[1] === 1'b1) rv_cnt[1]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model of a committed write: each enabled byte lane replaces the stored byte.
  task automatic model_write(input int k, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b);
    if (a < 32'd1024) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) model[k][a[9:0]][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  // Called and returns just after a falling edge; checks the whole access.
  task automatic access(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] obs);
    int          n;
    int          ws;
    logic [31:0] exp_rd;
    logic        exp_err;
    ws = (k == 0) ? 0 : 3;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    n = 0;
    while (ready[k] !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("ready_before_accept", {31'b0, ready[k]}, 32'd1);
    @(posedge clock);
    acc_cnt[k]++;
    exp_err = (a >= 32'd1024);
    if (w) begin
      model_write(k, a, d, b);
      exp_rd = last_rd[k];
    end else begin
      exp_rd = exp_err ? 32'd0 : model[k][a[9:0]];
    end
    #1 req[k] = 1'b0;
    for (int i = 0; i < ws; i++) begin
      @(negedge clock);
      chk("wait_ready_low", {31'b0, ready[k]}, 32'd0);
      chk("wait_no_rvalid", {31'b0, rvalid[k]}, 32'd0);
    end
    @(negedge clock);
    chk("rvalid", {31'b0, rvalid[k]}, 32'd1);
    chk("err", {31'b0, err[k]}, {31'b0, exp_err});
    chk("rdata", rdata[k], exp_rd);
    chk("ready_at_done", {31'b0, ready[k]}, 32'd1);
    obs = rdata[k];
    last_rd[k] = exp_rd;
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] a;
    logic [31:0] exp_y;

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1024; i++) model[k][i] = 32'd0;
      last_rd[k] = 32'd0; acc_cnt[k] = 0; rv_cnt[k] = 0;
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; be[k] = '0;
    end
    rst = 1'b1;
    @(negedge clock);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", {31'b0, ready[k]}, 32'd1);
      chk("reset_rvalid", {31'b0, rvalid[k]}, 32'd0);
      chk("reset_err", {31'b0, err[k]}, 32'd0);
      chk("reset_rdata", rdata[k], 32'd0);
    end
    rst = 1'b0;
    @(negedge clock);

    // Write then back-to-back read, no wait states.
    access(0, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, obs);
    access(0, 1'b0, 32'd5, 32'd0, 4'h0, obs);
    chk("t1_readback", obs, 32'hDEADBEEF);
    req[0] = 1'b0;
    @(negedge clock);
    chk("t1_rvalid_one_cycle", {31'b0, rvalid[0]}, 32'd0);

    // Byte-lane merge.
    access(0, 1'b1, 32'd9, 32'h11223344, 4'hF, obs);
    access(0, 1'b1, 32'd9, 32'hAABBCCDD, 4'b0101, obs);
    access(0, 1'b0, 32'd9, 32'd0, 4'h0, obs);
    chk("t2_merge", obs, 32'h11BB33DD);

    // Out of range, including an address whose low bits alias a valid word.
    access(0, 1'b0, 32'd1024, 32'd0, 4'h0, obs);
    access(0, 1'b1, 32'h400, 32'h55AA55AA, 4'hF, obs);
    access(0, 1'b0, 32'd0, 32'd0, 4'h0, obs);
    chk("t4_mem0_untouched", obs, 32'd0);
    access(0, 1'b0, 32'h8000_0005, 32'd0, 4'h0, obs);

    // Three wait states, with a second request held through the wait.
    access(1, 1'b1, 32'd20, 32'h0BADF00D, 4'hF, obs);
    access(1, 1'b1, 32'd21, 32'h12345678, 4'hF, obs);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'd20;
    @(posedge clock);
    acc_cnt[1]++;
    #1 addr[1] = 32'd21;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t3_ready_low", {31'b0, ready[1]}, 32'd0);
      chk("t3_no_rvalid", {31'b0, rvalid[1]}, 32'd0);
    end
    @(negedge clock);
    chk("t3_rvalid_first", {31'b0, rvalid[1]}, 32'd1);
    chk("t3_rdata_first", rdata[1], model[1][20]);
    chk("t3_ready_overlap", {31'b0, ready[1]}, 32'd1);
    @(posedge clock);
    acc_cnt[1]++;
    #1 req[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t3_held_ready_low", {31'b0, ready[1]}, 32'd0);
      chk("t3_held_no_rvalid", {31'b0, rvalid[1]}, 32'd0);
    end
    @(negedge clock);
    exp_y = 32'h12345678;
    chk("t3_rvalid_second", {31'b0, rvalid[1]}, 32'd1);
    chk("t3_rdata_second", rdata[1], exp_y);
    last_rd[1] = exp_y;

    // Reset during a pending write: completion dropped, write kept.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'd7; wdata[1] = 32'hCAFEF00D; be[1] = 4'hF;
    @(posedge clock);
    model_write(1, 32'd7, 32'hCAFEF00D, 4'hF);
    #1 req[1] = 1'b0;
    @(negedge clock);
    chk("t5_pending", {31'b0, ready[1]}, 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_ready_in_reset", {31'b0, ready[1]}, 32'd1);
    chk("t5_rdata_in_reset", rdata[1], 32'd0);
    @(negedge clock);
    rst = 1'b0;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("t5_no_rvalid", {31'b0, rvalid[1]}, 32'd0);
    end
    access(1, 1'b0, 32'd7, 32'd0, 4'h0, obs);
    chk("t5_write_kept", obs, 32'hCAFEF00D);

    // Random back-to-back traffic on the zero-wait instance.
    rv_cnt[0] = 0;
    acc_cnt[0] = 0;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 7) == 0) a = 32'(1024 + $urandom_range(0, 300));
      else a = 32'($urandom_range(0, 15));
      access(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), obs);
    end
    req[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rand_rvalid_count", 32'(rv_cnt[0]), 32'(acc_cnt[0]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
